// File: rtl/avst_cmd_avmm_master_pkg.sv
// Package avmm_mmio_pkg
// Shared definitions for the MMIO command responder: default widths, the
// request FSM state type and the bit positions of the read/write flags in the
// packed AV-ST command word {write, read, addr, wdata}.
package avmm_mmio_pkg;

    localparam int DEF_ADDR_WIDTH     = 18;
    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_RSP_FIFO_DEPTH = 8;

    // Flag positions for the default widths; parameterized users call the
    // helper functions below so the layout follows their own widths.
    localparam int CMD_WR_BIT = DEF_ADDR_WIDTH + DEF_DATA_WIDTH + 1;
    localparam int CMD_RD_BIT = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } t_req_state;

    function automatic int cmd_wr_pos(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

    function automatic int cmd_rd_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/avst_cmd_avmm_master_if.sv
// Interface avst_cmd_avmm_master_if
// Bundles the three buses of the MMIO command responder:
//   in_*   : AV-ST command sink  (in_data = {write, read, addr, wdata})
//   out_*  : AV-ST read-response source
//   avm_*  : single-beat Avalon-MM master
// Modport "master" is the responder's view, "slave" is the view of whatever
// surrounds it (command producer, response consumer and AVMM slave).
interface avst_cmd_avmm_master_if
    import avmm_mmio_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AVMM_DATA_WIDTH = DEF_DATA_WIDTH
);

    localparam int CMD_WIDTH = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 2;

    logic [CMD_WIDTH-1:0]         in_data;
    logic                         in_valid;
    logic                         in_ready;

    logic [AVMM_DATA_WIDTH-1:0]   out_data;
    logic                         out_valid;
    logic                         out_ready;

    logic [AVMM_ADDR_WIDTH-1:0]   avm_address;
    logic                         avm_read;
    logic                         avm_write;
    logic [AVMM_DATA_WIDTH-1:0]   avm_writedata;
    logic [AVMM_DATA_WIDTH/8-1:0] avm_byteenable;
    logic                         avm_waitrequest;
    logic [AVMM_DATA_WIDTH-1:0]   avm_readdata;
    logic                         avm_readdatavalid;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/avst_cmd_avmm_master_rsp_fifo.sv
// Module mmio_rsp_fifo
// Synchronous show-ahead FIFO holding AVMM read data until the response
// consumer takes it. The head entry is always visible on dout while !empty.
// Ports:
//   clk, SoftReset  clock and synchronous active-high reset (flushes the FIFO)
//   push, din       write an entry
//   pop             remove the head entry (ignored when empty)
//   dout            head entry
//   empty, full     occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. DEPTH must be a power of 2.
module mmio_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             SoftReset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is meaningless; a push on a full FIFO is only
    // allowed when the head leaves in the same cycle (it reuses that slot).
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/avst_cmd_avmm_master.sv
// Module avst_cmd_avmm_master
// Responder end of the MMIO command stream from the CCI-P MMIO bridge.
// Each accepted command is decoded into one single-beat Avalon-MM read or
// write; read data is buffered and returned in issue order on an AV-ST
// source.
// Ports:
//   clk        core clock (Clk_400)
//   SoftReset  synchronous active-high reset
//   bus        avst_cmd_avmm_master_if.master:
//                in_data/in_valid/in_ready      command sink
//                out_data/out_valid/out_ready   read-response source
//                avm_*                          Avalon-MM master
// A credit counter limits outstanding reads to the response buffer depth,
// so read data can always be absorbed and avm_readdatavalid never stalls.
module avst_cmd_avmm_master
    import avmm_mmio_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AVMM_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_FIFO_DEPTH  = DEF_RSP_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   SoftReset,
    avst_cmd_avmm_master_if.master bus
);

    localparam int CNT_WIDTH = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam int WR_BIT    = cmd_wr_pos(AVMM_ADDR_WIDTH, AVMM_DATA_WIDTH);
    localparam int RD_BIT    = cmd_rd_pos(AVMM_ADDR_WIDTH, AVMM_DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(RSP_FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    t_req_state                 state;
    t_req_state                 state_nxt;
    logic                       req_read;
    logic                       req_read_nxt;
    logic                       req_write;
    logic                       req_write_nxt;
    logic [AVMM_ADDR_WIDTH-1:0] req_addr;
    logic [AVMM_ADDR_WIDTH-1:0] req_addr_nxt;
    logic [AVMM_DATA_WIDTH-1:0] req_wdata;
    logic [AVMM_DATA_WIDTH-1:0] req_wdata_nxt;

    logic [CNT_WIDTH-1:0]       credits;
    logic [CNT_WIDTH-1:0]       outstanding;

    logic                       cmd_wr;
    logic                       cmd_rd;
    logic [AVMM_ADDR_WIDTH-1:0] cmd_addr;
    logic [AVMM_DATA_WIDTH-1:0] cmd_wdata;
    logic                       in_ready_int;
    logic                       cmd_accept;
    logic                       rd_accept;
    logic                       rd_taken;
    logic                       rd_beat_ok;
    logic                       rsp_push;
    logic                       rsp_pop;

    logic [AVMM_DATA_WIDTH-1:0] fifo_dout;
    logic                       fifo_empty;
    logic                       fifo_full;

    // Command field extraction
    assign cmd_wr    = bus.in_data[WR_BIT];
    assign cmd_rd    = bus.in_data[RD_BIT];
    assign cmd_addr  = bus.in_data[RD_BIT-1 -: AVMM_ADDR_WIDTH];
    assign cmd_wdata = bus.in_data[AVMM_DATA_WIDTH-1:0];

    // Accept only in IDLE with a free response slot; reset blocks acceptance
    // in the reset cycle itself.
    assign in_ready_int = (state == IDLE) && (credits != '0) && !SoftReset;
    assign cmd_accept   = bus.in_valid && in_ready_int;

    // Write wins when both flags are set, so only a pure read costs a credit.
    assign rd_accept = cmd_accept && cmd_rd && !cmd_wr;
    assign rd_taken  = req_read && !bus.avm_waitrequest;

    // Only beats that answer a read issued since the last reset are kept;
    // stragglers from before a reset find outstanding == 0 and are dropped.
    assign rd_beat_ok = bus.avm_readdatavalid && (outstanding != '0);
    assign rsp_push   = rd_beat_ok && !SoftReset;
    assign rsp_pop    = !fifo_empty && bus.out_ready;

    // Next-state and next request register values; the AVMM request is
    // registered so it appears the cycle after the command is accepted and
    // stays frozen while the slave asserts waitrequest.
    always_comb begin
        state_nxt     = state;
        req_read_nxt  = req_read;
        req_write_nxt = req_write;
        req_addr_nxt  = req_addr;
        req_wdata_nxt = req_wdata;

        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_wr) begin
                        state_nxt     = REQ;
                        req_write_nxt = 1'b1;
                        req_read_nxt  = 1'b0;
                        req_addr_nxt  = cmd_addr;
                        req_wdata_nxt = cmd_wdata;
                    end else if (cmd_rd) begin
                        state_nxt     = REQ;
                        req_read_nxt  = 1'b1;
                        req_write_nxt = 1'b0;
                        req_addr_nxt  = cmd_addr;
                    end
                end
            end
            REQ: begin
                if (!bus.avm_waitrequest) begin
                    state_nxt     = IDLE;
                    req_read_nxt  = 1'b0;
                    req_write_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                req_read_nxt  = 1'b0;
                req_write_nxt = 1'b0;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state     <= IDLE;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state     <= state_nxt;
            req_read  <= req_read_nxt;
            req_write <= req_write_nxt;
            req_addr  <= req_addr_nxt;
            req_wdata <= req_wdata_nxt;
        end
    end

    // Response-slot credits: spent when a read is accepted, returned when its
    // response is consumed; both in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            credits <= CREDIT_MAX;
        end else if (rd_accept && !rsp_pop) begin
            credits <= credits - CNT_ONE;
        end else if (!rd_accept && rsp_pop) begin
            credits <= credits + CNT_ONE;
        end
    end

    // Reads taken by the slave whose data has not yet come back.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            outstanding <= '0;
        end else if (rd_taken && !rd_beat_ok) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (!rd_taken && rd_beat_ok) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end

    // Credits guarantee space, so a push into a full buffer without a
    // simultaneous pop means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!SoftReset) begin
            assert (!(rsp_push && fifo_full && !rsp_pop));
        end
    end

    mmio_rsp_fifo #(
        .WIDTH (AVMM_DATA_WIDTH),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .SoftReset (SoftReset),
        .push      (rsp_push),
        .din       (bus.avm_readdata),
        .pop       (rsp_pop),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.in_ready       = in_ready_int;
    assign bus.out_data       = fifo_dout;
    assign bus.out_valid      = !fifo_empty;
    assign bus.avm_address    = req_addr;
    assign bus.avm_read       = req_read;
    assign bus.avm_write      = req_write;
    assign bus.avm_writedata  = req_wdata;
    assign bus.avm_byteenable = '1;

endmodule

// File: tb/tb_avst_cmd_avmm_master.sv
// Testbench for avst_cmd_avmm_master: directed scenarios with a simple
// Avalon-MM slave model that returns queued read data after a programmable
// latency and counts completed reads and writes.
module tb_avst_cmd_avmm_master;

    localparam int A     = 18;
    localparam int D     = 64;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic soft_reset;

    int total = 0;
    int bad   = 0;

    int          cyc         = 0;
    int          rd_latency  = 3;
    int          read_count  = 0;
    int          write_count = 0;
    int          due_q[$];
    logic [D-1:0] dat_q[$];
    logic [D-1:0] rd_list[$];

    avst_cmd_avmm_master_if #(.AVMM_ADDR_WIDTH(A), .AVMM_DATA_WIDTH(D)) bus ();

    avst_cmd_avmm_master #(
        .AVMM_ADDR_WIDTH (A),
        .AVMM_DATA_WIDTH (D),
        .RSP_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .SoftReset (soft_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Slave model: looks at the bus 2ns after each edge, after the stimulus
    // for that cycle has settled. A read taken at the coming edge returns its
    // data rd_latency cycles later.
    initial begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (bus.avm_read && !bus.avm_waitrequest) begin
                read_count++;
                due_q.push_back(cyc + rd_latency);
                if (rd_list.size() > 0) dat_q.push_back(rd_list.pop_front());
                else dat_q.push_back(64'hBAD0);
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                write_count++;
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and returns once it is accepted (positioned 1ns
    // after the accepting edge) or the budget runs out.
    task automatic send_cmd(input logic wr, input logic rd, input logic [A-1:0] addr,
                            input logic [D-1:0] wdata, input int budget, output bit accepted);
        int n = 0;
        bus.in_data  = {wr, rd, addr, wdata};
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < budget) begin
            step();
            n++;
        end
        accepted = bus.in_ready;
        if (accepted) step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        soft_reset          = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_data         = '0;
        bus.out_ready       = 1'b1;
        bus.avm_waitrequest = 1'b0;
        repeat (3) step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.avm_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_avm_read got=%0h exp=0", bus.avm_read); end
        total++; if (bus.avm_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_avm_write got=%0h exp=0", bus.avm_write); end
        total++; if (bus.avm_address !== 18'h0) begin bad++; $display("[TB] FAIL reset_address got=%0h exp=0", bus.avm_address); end
        total++; if (bus.avm_writedata !== 64'h0) begin bad++; $display("[TB] FAIL reset_writedata got=%0h exp=0", bus.avm_writedata); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
        total++; if (dut.credits !== 4'd8) begin bad++; $display("[TB] FAIL reset_credits got=%0d exp=8", dut.credits); end
        soft_reset = 1'b0;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready got=%0h exp=1", bus.in_ready); end
    endtask

    task automatic test_write();
        bit ok;
        int wc0 = write_count;
        bus.avm_waitrequest = 1'b0;
        send_cmd(1'b1, 1'b0, 18'h80, 64'hDEADBEEF_CAFEF00D, 10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL wr_accept got=0 exp=1"); end
        total++; if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0) begin bad++; $display("[TB] FAIL wr_strobe got=w%0h r%0h exp=w1 r0", bus.avm_write, bus.avm_read); end
        total++; if (bus.avm_address !== 18'h80) begin bad++; $display("[TB] FAIL wr_address got=%0h exp=80", bus.avm_address); end
        total++; if (bus.avm_writedata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("[TB] FAIL wr_data got=%0h exp=deadbeefcafef00d", bus.avm_writedata); end
        total++; if (bus.avm_byteenable !== 8'hFF) begin bad++; $display("[TB] FAIL wr_byteenable got=%0h exp=ff", bus.avm_byteenable); end
        step();
        total++; if (bus.avm_write !== 1'b0) begin bad++; $display("[TB] FAIL wr_one_cycle got=%0h exp=0", bus.avm_write); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_no_response got=%0h exp=0", bus.out_valid); end
        step();
        total++; if (write_count !== wc0 + 1) begin bad++; $display("[TB] FAIL wr_count got=%0d exp=%0d", write_count, wc0 + 1); end
    endtask

    task automatic test_read();
        bit ok;
        int n = 0;
        rd_list.push_back(64'h1234);
        rd_latency    = 5;
        bus.out_ready = 1'b1;
        send_cmd(1'b0, 1'b1, 18'h80, 64'h0, 10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rd_accept got=0 exp=1"); end
        total++; if (bus.avm_read !== 1'b1 || bus.avm_address !== 18'h80) begin bad++; $display("[TB] FAIL rd_request got=r%0h a%0h exp=r1 a80", bus.avm_read, bus.avm_address); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rd_busy_in_ready got=%0h exp=0", bus.in_ready); end
        step();
        total++; if (bus.avm_read !== 1'b0) begin bad++; $display("[TB] FAIL rd_deassert got=%0h exp=0", bus.avm_read); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rd_ready_again got=%0h exp=1", bus.in_ready); end
        while (!bus.out_valid && n < 20) begin step(); n++; end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rd_timeout got=%0h exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 64'h1234) begin bad++; $display("[TB] FAIL rd_data got=%0h exp=1234", bus.out_data); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_popped got=%0h exp=0", bus.out_valid); end
    endtask

    task automatic test_wait_hold();
        bit ok;
        bit held = 1'b1;
        int wc0 = write_count;
        bus.avm_waitrequest = 1'b1;
        send_cmd(1'b1, 1'b0, 18'h3_0008, 64'h0123_4567_89AB_CDEF, 10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL wait_accept got=0 exp=1"); end
        for (int i = 0; i < 10; i++) begin
            if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_address !== 18'h3_0008 ||
                bus.avm_writedata !== 64'h0123_4567_89AB_CDEF || bus.in_ready !== 1'b0)
                held = 1'b0;
            step();
        end
        total++; if (!held) begin bad++; $display("[TB] FAIL wait_stable got=0 exp=1"); end
        bus.avm_waitrequest = 1'b0;
        step();
        total++; if (bus.avm_write !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL wait_release got=w%0h rdy%0h exp=w0 rdy1", bus.avm_write, bus.in_ready); end
        total++; if (write_count !== wc0 + 1) begin bad++; $display("[TB] FAIL wait_single_write got=%0d exp=%0d", write_count, wc0 + 1); end
    endtask

    task automatic test_credit_full();
        bit ok;
        bit pending = 1'b0;
        bit got9 = 1'b0;
        int n = 0;
        bus.out_ready       = 1'b0;
        bus.avm_waitrequest = 1'b0;
        rd_latency          = 3;
        for (int i = 1; i <= 9; i++) rd_list.push_back(64'(i));
        for (int i = 0; i < 8; i++) begin
            send_cmd(1'b0, 1'b1, 18'(i * 8), 64'h0, 10, ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL credit_accept_%0d got=0 exp=1", i); end
        end
        send_cmd(1'b0, 1'b1, 18'h40, 64'h0, 20, ok);
        total++; if (ok) begin bad++; $display("[TB] FAIL credit_block_9th got=1 exp=0"); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL credit_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd1) begin bad++; $display("[TB] FAIL credit_head got=v%0h d%0h exp=v1 d1", bus.out_valid, bus.out_data); end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'(i)) begin bad++; $display("[TB] FAIL credit_order_%0d got=v%0h d%0h exp=v1 d%0h", i, bus.out_valid, bus.out_data, i); end
            if (bus.in_valid && bus.in_ready) pending = 1'b1;
            step();
            if (pending) begin
                bus.in_valid = 1'b0;
                got9 = 1'b1;
                pending = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        total++; if (!got9) begin bad++; $display("[TB] FAIL credit_9th_accept got=0 exp=1"); end
        while (!bus.out_valid && n < 20) begin step(); n++; end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd9) begin bad++; $display("[TB] FAIL credit_9th_data got=v%0h d%0h exp=v1 d9", bus.out_valid, bus.out_data); end
        step();
        total++; if (bus.out_valid !== 1'b0 || dut.credits !== 4'd8) begin bad++; $display("[TB] FAIL credit_restored got=v%0h c%0d exp=v0 c8", bus.out_valid, dut.credits); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        int n = 0;
        bus.out_ready       = 1'b1;
        bus.avm_waitrequest = 1'b0;
        rd_latency          = 8;
        rd_list.push_back(64'hAAAA);
        send_cmd(1'b0, 1'b1, 18'h40, 64'h0, 10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rst_first_accept got=0 exp=1"); end
        step();
        bus.avm_waitrequest = 1'b1;
        send_cmd(1'b0, 1'b1, 18'h48, 64'h0, 10, ok);
        step();
        total++; if (!ok || bus.avm_read !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_req got=%0h exp=1", bus.avm_read); end
        soft_reset = 1'b1;
        step();
        total++; if (bus.avm_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_avm_read got=%0h exp=0", bus.avm_read); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%0h exp=0", bus.out_valid); end
        total++; if (dut.credits !== 4'd8) begin bad++; $display("[TB] FAIL rst_credits got=%0d exp=8", dut.credits); end
        soft_reset          = 1'b0;
        bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL rst_late_beat_dropped got=1 exp=0"); end
        rd_latency = 2;
        rd_list.push_back(64'h5555);
        send_cmd(1'b0, 1'b1, 18'h50, 64'h0, 10, ok);
        while (!bus.out_valid && n < 20) begin step(); n++; end
        total++; if (!ok || bus.out_data !== 64'h5555) begin bad++; $display("[TB] FAIL rst_fresh_read got=%0h exp=5555", bus.out_data); end
        step();
    endtask

    task automatic test_cmd_decode();
        bit ok;
        bit quiet = 1'b1;
        int wc0, rc0;
        bus.out_ready       = 1'b1;
        bus.avm_waitrequest = 1'b0;
        wc0 = write_count;
        rc0 = read_count;
        send_cmd(1'b1, 1'b1, 18'h200, 64'h77, 10, ok);
        total++; if (!ok || bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0) begin bad++; $display("[TB] FAIL dec_both_write got=w%0h r%0h exp=w1 r0", bus.avm_write, bus.avm_read); end
        total++; if (bus.avm_address !== 18'h200 || bus.avm_writedata !== 64'h77) begin bad++; $display("[TB] FAIL dec_both_fields got=a%0h d%0h exp=a200 d77", bus.avm_address, bus.avm_writedata); end
        step();
        send_cmd(1'b0, 1'b0, 18'h300, 64'h99, 10, ok);
        total++; if (!ok || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL dec_nop_idle got=%0h exp=1", bus.in_ready); end
        for (int i = 0; i < 8; i++) begin
            if (bus.avm_read || bus.avm_write || bus.out_valid) quiet = 1'b0;
            step();
        end
        total++; if (!quiet) begin bad++; $display("[TB] FAIL dec_nop_quiet got=0 exp=1"); end
        total++; if (write_count !== wc0 + 1 || read_count !== rc0) begin bad++; $display("[TB] FAIL dec_counts got=w%0d r%0d exp=w%0d r%0d", write_count, read_count, wc0 + 1, rc0); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        test_reset();
        test_write();
        test_read();
        test_wait_hold();
        test_credit_full();
        test_reset_mid();
        test_cmd_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
